// File: rtl/mjpg_entropy_scheduler.sv
// MJPEG entropy scheduler: sequences every packer write for one frame.
// Emits the byte-alignment pad and the frame header (with width/height
// patched in), then drives per-MCU Y/Cb/Cr request slots to the three
// component encoders. The encoders' length/data outputs and the scheduler's
// own pad/header words are merged through one register stage onto the
// packer port. Collisions and protocol misuse raise a sticky error.
module mjpg_entropy_scheduler #(
    parameter int LEN_FH     = 171,
    parameter int HDR_START  = 2,
    parameter int DCT_TH_Y   = 4,
    parameter int DCT_TH_C   = 2,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [11:0] width,
    input  logic [11:0] height,
    input  logic        band_ready,
    input  logic [2:0]  bs_rest,
    output logic [7:0]  fh_addr,
    input  logic [7:0]  fh_data,
    output logic [2:0]  ce_req,
    output logic [7:0]  ce_x_mcu,
    input  logic [17:0] ce_elen,
    input  logic [95:0] ce_edata,
    output logic [5:0]  elen,
    output logic [31:0] edata,
    output logic [31:0] edata_nostuff,
    output logic        busy,
    output logic        err
);

    localparam logic [7:0] HDR_FIRST = 8'(HDR_START);
    localparam logic [7:0] HDR_LAST  = 8'(LEN_FH - 1);
    localparam logic [7:0] TH_Y      = 8'(DCT_TH_Y);
    localparam logic [7:0] TH_C      = 8'(DCT_TH_C);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    // Header ROM indices replaced by the sampled frame dimensions
    localparam logic [7:0] IDX_H_HI = 8'd143;
    localparam logic [7:0] IDX_H_LO = 8'd144;
    localparam logic [7:0] IDX_W_HI = 8'd145;
    localparam logic [7:0] IDX_W_LO = 8'd146;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_HDR   = 3'd2,
        S_WAIT  = 3'd3,
        S_Y     = 3'd4,
        S_CB    = 3'd5,
        S_CR    = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    // True when more than one source presents a nonzero length
    function automatic logic multi_src(input logic [3:0] nz);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, nz[i]};
        end
        return (n > 3'd1);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [7:0]  x_r;
    logic [7:0]  x_next_s;
    logic [7:0]  band_r;
    logic [7:0]  band_next_s;
    logic [7:0]  cnt_r;
    logic [10:0] width_r;
    logic [10:0] height_r;
    logic [7:0]  h_mcu_s;
    logic [7:0]  v_mcu_s;
    logic [7:0]  hdr_idx_s;

    logic [5:0]  fsm_len_s;
    logic [31:0] fsm_data_s;
    logic [7:0]  hdr_byte_s;
    logic [2:0]  req_next_s;
    logic [7:0]  x_out_next_s;
    logic [31:0] nostuff_next_s;
    logic [7:0]  addr_next_s;

    logic [5:0]  len_y_s;
    logic [5:0]  len_cb_s;
    logic [5:0]  len_cr_s;
    logic [3:0]  nz_s;
    logic [5:0]  len_or_s;
    logic [31:0] data_or_s;
    logic        collide_s;
    logic        err_set_s;

    logic [5:0]  elen_r;
    logic [31:0] edata_r;
    logic [31:0] nostuff_r;
    logic [2:0]  ce_req_r;
    logic [7:0]  ce_x_r;
    logic        busy_r;
    logic        err_r;
    logic [7:0]  fh_addr_r;

    // Dimension bit 11 exceeds the 11-bit MCU range and is ignored
    logic unused_dim_s;
    assign unused_dim_s = &{1'b0, width[11], height[11]};

    assign h_mcu_s   = width_r[10:3];
    assign v_mcu_s   = height_r[10:3];
    // The address runs one ahead of the byte currently on fh_data
    assign hdr_idx_s = fh_addr_r - 8'd1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic together with next MCU column and band count
    always_comb begin
        state_next_s = state_r;
        x_next_s     = x_r;
        band_next_s  = band_r;
        if (frame_start) begin
            // A frame start always restarts the frame, even mid-frame
            state_next_s = S_ALIGN;
            x_next_s     = 8'd0;
            band_next_s  = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_next_s = S_IDLE;
                end
                S_ALIGN: begin
                    state_next_s = S_HDR;
                end
                S_HDR: begin
                    if (hdr_idx_s == HDR_LAST) begin
                        state_next_s = S_WAIT;
                        band_next_s  = 8'd0;
                    end else begin
                        state_next_s = S_HDR;
                    end
                end
                S_WAIT: begin
                    if (band_r == v_mcu_s) begin
                        state_next_s = S_IDLE;
                    end else if (band_ready) begin
                        if (h_mcu_s == 8'd0) begin
                            // Zero-width band: nothing to encode, just count it
                            band_next_s = band_r + 8'd1;
                        end else begin
                            state_next_s = S_Y;
                            x_next_s     = 8'd0;
                        end
                    end else begin
                        state_next_s = S_WAIT;
                    end
                end
                S_Y: begin
                    if (cnt_r == TH_Y) begin
                        state_next_s = S_CB;
                    end else begin
                        state_next_s = S_Y;
                    end
                end
                S_CB: begin
                    if (cnt_r == TH_C) begin
                        state_next_s = S_CR;
                    end else begin
                        state_next_s = S_CB;
                    end
                end
                S_CR: begin
                    if (cnt_r != TH_C) begin
                        state_next_s = S_CR;
                    end else if (x_r == h_mcu_s - 8'd1) begin
                        state_next_s = S_GAP;
                    end else begin
                        state_next_s = S_Y;
                        x_next_s     = x_r + 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_next_s = S_WAIT;
                        band_next_s  = band_r + 8'd1;
                    end else begin
                        state_next_s = S_GAP;
                    end
                end
                default: begin
                    state_next_s = S_IDLE;
                end
            endcase
        end
    end

    // Output decode: own pad/header word, next-cycle request, column, ROM address
    always_comb begin
        case (hdr_idx_s)
            IDX_H_HI: hdr_byte_s = {5'b00000, height_r[10:8]};
            IDX_H_LO: hdr_byte_s = height_r[7:0];
            IDX_W_HI: hdr_byte_s = {5'b00000, width_r[10:8]};
            IDX_W_LO: hdr_byte_s = width_r[7:0];
            default:  hdr_byte_s = fh_data;
        endcase

        case (state_r)
            S_ALIGN: begin
                fsm_len_s  = {3'b000, bs_rest};
                fsm_data_s = 32'h0000_00FF;
            end
            S_HDR: begin
                fsm_len_s  = 6'd8;
                fsm_data_s = {24'h00_0000, hdr_byte_s};
            end
            default: begin
                fsm_len_s  = 6'd0;
                fsm_data_s = 32'h0000_0000;
            end
        endcase

        if (state_r == S_ALIGN || state_r == S_HDR) begin
            nostuff_next_s = 32'h0000_00FF;
        end else begin
            nostuff_next_s = 32'h0000_0000;
        end

        // Requests are registered from the next state so they assert in the
        // first cycle of their slot
        case (state_next_s)
            S_Y:     req_next_s = 3'b001;
            S_CB:    req_next_s = 3'b010;
            S_CR:    req_next_s = 3'b100;
            default: req_next_s = 3'b000;
        endcase

        if (state_next_s == S_Y || state_next_s == S_CB || state_next_s == S_CR) begin
            x_out_next_s = x_next_s;
        end else begin
            x_out_next_s = 8'd0;
        end

        // The first header address is issued during ALIGN
        if (state_next_s == S_ALIGN) begin
            addr_next_s = HDR_FIRST;
        end else if (state_next_s == S_HDR) begin
            addr_next_s = fh_addr_r + 8'd1;
        end else begin
            addr_next_s = 8'd0;
        end
    end

    // Slot counter: cleared on any state change, counts cycles inside a slot
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (frame_start || (state_next_s != state_r)) begin
            cnt_r <= 8'd0;
        end else if (state_r == S_Y || state_r == S_CB || state_r == S_CR || state_r == S_GAP) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= 8'd0;
        end
    end

    // Frame dimensions, MCU column and band counter
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r      <= 8'd0;
            band_r   <= 8'd0;
            width_r  <= 11'd0;
            height_r <= 11'd0;
        end else begin
            x_r    <= x_next_s;
            band_r <= band_next_s;
            if (frame_start) begin
                width_r  <= width[10:0];
                height_r <= height[10:0];
            end else begin
                width_r  <= width_r;
                height_r <= height_r;
            end
        end
    end

    // Source merge: mask each word by its own length, detect overlapping sources
    always_comb begin
        len_y_s   = ce_elen[5:0];
        len_cb_s  = ce_elen[11:6];
        len_cr_s  = ce_elen[17:12];
        nz_s      = {(fsm_len_s != 6'd0), (len_cr_s != 6'd0),
                     (len_cb_s != 6'd0), (len_y_s != 6'd0)};
        len_or_s  = fsm_len_s | len_y_s | len_cb_s | len_cr_s;
        data_or_s = (nz_s[0] ? ce_edata[31:0]  : 32'h0000_0000) |
                    (nz_s[1] ? ce_edata[63:32] : 32'h0000_0000) |
                    (nz_s[2] ? ce_edata[95:64] : 32'h0000_0000) |
                    (nz_s[3] ? fsm_data_s      : 32'h0000_0000);
        collide_s = multi_src(nz_s);
        err_set_s = collide_s |
                    (band_ready && (state_r != S_WAIT)) |
                    (frame_start && (state_r != S_IDLE));
    end

    // Registered outputs: merged packer word, requests, ROM address, status
    always_ff @(posedge clk) begin
        if (rst) begin
            elen_r    <= 6'd0;
            edata_r   <= 32'h0000_0000;
            nostuff_r <= 32'h0000_0000;
            ce_req_r  <= 3'b000;
            ce_x_r    <= 8'd0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
            fh_addr_r <= 8'd0;
        end else begin
            elen_r    <= collide_s ? 6'd0 : len_or_s;
            edata_r   <= data_or_s;
            nostuff_r <= nostuff_next_s;
            ce_req_r  <= req_next_s;
            ce_x_r    <= x_out_next_s;
            busy_r    <= (state_next_s != S_IDLE);
            err_r     <= err_r | err_set_s;
            fh_addr_r <= addr_next_s;
        end
    end

    assign elen          = elen_r;
    assign edata         = edata_r;
    assign edata_nostuff = nostuff_r;
    assign ce_req        = ce_req_r;
    assign ce_x_mcu      = ce_x_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign fh_addr       = fh_addr_r;

endmodule

// File: tb/tb_mjpg_entropy_scheduler.sv
// Directed scoreboard bench for mjpg_entropy_scheduler. Expected values are
// queued with the cycle at which they must appear and compared at negedge.
module tb_mjpg_entropy_scheduler;

    localparam int K_OUT  = 0;
    localparam int K_REQ  = 1;
    localparam int K_ERR  = 2;
    localparam int K_BUSY = 3;
    localparam int K_ADDR = 4;
    localparam int K_LEN  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          tag;
    } item_t;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [11:0] width;
    logic [11:0] height;
    logic        band_ready;
    logic [2:0]  bs_rest;
    logic [7:0]  fh_addr;
    logic [7:0]  fh_data;
    logic [2:0]  ce_req;
    logic [7:0]  ce_x_mcu;
    logic [17:0] ce_elen;
    logic [95:0] ce_edata;
    logic [5:0]  elen;
    logic [31:0] edata;
    logic [31:0] edata_nostuff;
    logic        busy;
    logic        err;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    last_target = 0;
    item_t sb_q[$];
    item_t it;

    localparam logic [95:0] EDATA_IDLE = {32'hCAFE_F00D, 32'h1234_5678, 32'hFFFF_FFFF};

    mjpg_entropy_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .width         (width),
        .height        (height),
        .band_ready    (band_ready),
        .bs_rest       (bs_rest),
        .fh_addr       (fh_addr),
        .fh_data       (fh_data),
        .ce_req        (ce_req),
        .ce_x_mcu      (ce_x_mcu),
        .ce_elen       (ce_elen),
        .ce_edata      (ce_edata),
        .elen          (elen),
        .edata         (edata),
        .edata_nostuff (edata_nostuff),
        .busy          (busy),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_val(input int i);
        return 8'((i * 37 + 11) % 256);
    endfunction

    // Synchronous header ROM model, one cycle of read latency
    always @(posedge clk) fh_data <= rom_val(int'(fh_addr));

    function automatic logic [7:0] hdr_byte(input int idx, input logic [11:0] w, input logic [11:0] h);
        case (idx)
            143:     return {5'b00000, h[10:8]};
            144:     return h[7:0];
            145:     return {5'b00000, w[10:8]};
            146:     return w[7:0];
            default: return rom_val(idx);
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc <= cyc) begin
                it = sb_q[i];
                sb_q.delete(i);
                checks++;
                if (it.cyc != cyc) begin
                    errors++;
                    $error("FAIL stale tag=%0d got cyc=%0d want cyc=%0d", it.tag, cyc, it.cyc);
                end else begin
                    case (it.kind)
                        K_OUT: assert ({elen, edata, edata_nostuff} === {it.a[5:0], it.b, it.c}) else begin
                            errors++;
                            $error("FAIL out tag=%0d cyc=%0d got elen=%0d edata=%h ns=%h want elen=%0d edata=%h ns=%h",
                                   it.tag, cyc, elen, edata, edata_nostuff, it.a[5:0], it.b, it.c);
                        end
                        K_REQ: assert ({ce_req, ce_x_mcu} === {it.a[2:0], it.b[7:0]}) else begin
                            errors++;
                            $error("FAIL req tag=%0d cyc=%0d got req=%b x=%0d want req=%b x=%0d",
                                   it.tag, cyc, ce_req, ce_x_mcu, it.a[2:0], it.b[7:0]);
                        end
                        K_ERR: assert (err === it.a[0]) else begin
                            errors++;
                            $error("FAIL err tag=%0d cyc=%0d got %b want %b", it.tag, cyc, err, it.a[0]);
                        end
                        K_BUSY: assert (busy === it.a[0]) else begin
                            errors++;
                            $error("FAIL busy tag=%0d cyc=%0d got %b want %b", it.tag, cyc, busy, it.a[0]);
                        end
                        K_ADDR: assert (fh_addr === it.a[7:0]) else begin
                            errors++;
                            $error("FAIL addr tag=%0d cyc=%0d got %0d want %0d", it.tag, cyc, fh_addr, it.a[7:0]);
                        end
                        default: assert (elen === it.a[5:0]) else begin
                            errors++;
                            $error("FAIL len tag=%0d cyc=%0d got %0d want %0d", it.tag, cyc, elen, it.a[5:0]);
                        end
                    endcase
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] cc, input int tag);
        item_t n;
        n.cyc  = c;
        n.kind = k;
        n.a    = a;
        n.b    = b;
        n.c    = cc;
        n.tag  = tag;
        sb_q.push_back(n);
        if (c > last_target) last_target = c;
    endtask

    // Reset for two cycles; every output must read zero while held
    task automatic rst_seq();
        int r;
        r = cyc;
        rst = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            push(r + k, K_OUT,  32'd0, 32'd0, 32'd0, 10);
            push(r + k, K_REQ,  32'd0, 32'd0, 32'd0, 11);
            push(r + k, K_ERR,  32'd0, 32'd0, 32'd0, 12);
            push(r + k, K_BUSY, 32'd0, 32'd0, 32'd0, 13);
            push(r + k, K_ADDR, 32'd0, 32'd0, 32'd0, 14);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Pad at f+2, 169 header bytes back-to-back from f+3 for a frame_start driven in cycle f
    task automatic push_frame_hdr(input int f, input logic [11:0] w, input logic [11:0] h, input logic [2:0] rest);
        push(f + 1, K_BUSY, 32'd1, 32'd0, 32'd0, 20);
        push(f + 1, K_ADDR, 32'd2, 32'd0, 32'd0, 21);
        push(f + 2, K_OUT, {29'd0, rest}, (rest != 3'd0) ? 32'h0000_00FF : 32'd0, 32'h0000_00FF, 22);
        for (int j = 0; j < 169; j++) begin
            push(f + 3 + j, K_OUT, 32'd8, {24'd0, hdr_byte(2 + j, w, h)}, 32'h0000_00FF, 1000 + 2 + j);
        end
        push(f + 172, K_OUT, 32'd0, 32'd0, 32'd0, 23);
    endtask

    // Slot pattern: Y x5, Cb x3, Cr x3 per MCU, then 8 gap cycles and a WAIT cycle
    task automatic push_band(input int b, input int nmcu);
        int k;
        int req_v;
        for (int i = 0; i < nmcu * 11; i++) begin
            k = i % 11;
            req_v = (k < 5) ? 1 : ((k < 8) ? 2 : 4);
            push(b + 1 + i, K_REQ, 32'(req_v), 32'(i / 11), 32'd0, 200 + i);
        end
        for (int g = 0; g < 9; g++) begin
            push(b + 1 + nmcu * 11 + g, K_REQ, 32'd0, 32'd0, 32'd0, 300 + g);
        end
    endtask

    initial begin
        int f;
        int b;
        int b2;
        int c;
        rst         = 1'b1;
        frame_start = 1'b0;
        width       = 12'd0;
        height      = 12'd0;
        band_ready  = 1'b0;
        bs_rest     = 3'd0;
        ce_elen     = 18'd0;
        ce_edata    = EDATA_IDLE;
        tick();
        rst_seq();

        // Header with 640x480 and a 3-bit pad
        width = 12'd640; height = 12'd480; bs_rest = 3'd3;
        f = cyc;
        frame_start = 1'b1;
        push_frame_hdr(f, 12'd640, 12'd480, 3'd3);
        push(f + 172, K_ERR, 32'd0, 32'd0, 32'd0, 30);
        tick();
        frame_start = 1'b0;
        wait_until(f + 175);
        rst_seq();

        // 16x16: two bands of two MCUs, lone Cr word, end of frame, late band
        width = 12'd16; height = 12'd16; bs_rest = 3'd0;
        f = cyc;
        frame_start = 1'b1;
        push_frame_hdr(f, 12'd16, 12'd16, 3'd0);
        tick();
        frame_start = 1'b0;
        wait_until(f + 171);
        b = cyc;
        band_ready = 1'b1;
        push_band(b, 2);
        tick();
        band_ready = 1'b0;
        wait_until(b + 25);
        ce_elen  = {6'd20, 6'd0, 6'd0};
        ce_edata = {32'h000A_BCDE, 32'h1234_5678, 32'hFFFF_FFFF};
        push(b + 26, K_OUT, 32'd20, 32'h000A_BCDE, 32'd0, 40);
        push(b + 26, K_ERR, 32'd0, 32'd0, 32'd0, 41);
        tick();
        ce_elen  = 18'd0;
        ce_edata = EDATA_IDLE;
        wait_until(b + 31);
        b2 = cyc;
        band_ready = 1'b1;
        push_band(b2, 2);
        push(b2 + 31, K_BUSY, 32'd1, 32'd0, 32'd0, 42);
        push(b2 + 32, K_BUSY, 32'd0, 32'd0, 32'd0, 43);
        push(b2 + 32, K_ERR,  32'd0, 32'd0, 32'd0, 44);
        tick();
        band_ready = 1'b0;
        wait_until(b2 + 33);
        band_ready = 1'b1;
        push(b2 + 34, K_ERR, 32'd1, 32'd0, 32'd0, 45);
        push(b2 + 34, K_REQ, 32'd0, 32'd0, 32'd0, 46);
        tick();
        band_ready = 1'b0;
        tick();
        rst_seq();

        // Collision between Y and Cb in IDLE
        c = cyc;
        push(c, K_ERR, 32'd0, 32'd0, 32'd0, 50);
        ce_elen = {6'd0, 6'd7, 6'd12};
        push(c + 1, K_LEN, 32'd0, 32'd0, 32'd0, 51);
        push(c + 1, K_ERR, 32'd1, 32'd0, 32'd0, 52);
        tick();
        ce_elen = 18'd0;
        tick();
        rst_seq();

        // 8x16: band_ready in the last GAP cycle is dropped and flagged
        width = 12'd8; height = 12'd16; bs_rest = 3'd1;
        f = cyc;
        frame_start = 1'b1;
        push_frame_hdr(f, 12'd8, 12'd16, 3'd1);
        tick();
        frame_start = 1'b0;
        wait_until(f + 171);
        b = cyc;
        band_ready = 1'b1;
        push_band(b, 1);
        tick();
        band_ready = 1'b0;
        wait_until(b + 19);
        push(b + 19, K_ERR, 32'd0, 32'd0, 32'd0, 60);
        band_ready = 1'b1;
        push(b + 20, K_ERR, 32'd1, 32'd0, 32'd0, 61);
        push(b + 21, K_REQ, 32'd0, 32'd0, 32'd0, 62);
        tick();
        band_ready = 1'b0;
        wait_until(b + 21);
        b2 = cyc;
        band_ready = 1'b1;
        push(b2 + 1, K_REQ, 32'd1, 32'd0, 32'd0, 63);
        tick();
        band_ready = 1'b0;
        wait_until(b2 + 3);
        rst_seq();

        // Restart while in CB: new dimensions appear in the header
        width = 12'd16; height = 12'd16; bs_rest = 3'd0;
        f = cyc;
        frame_start = 1'b1;
        push_frame_hdr(f, 12'd16, 12'd16, 3'd0);
        tick();
        frame_start = 1'b0;
        wait_until(f + 171);
        b = cyc;
        band_ready = 1'b1;
        push(b + 1, K_REQ, 32'd1, 32'd0, 32'd0, 70);
        push(b + 6, K_REQ, 32'd2, 32'd0, 32'd0, 71);
        tick();
        band_ready = 1'b0;
        wait_until(b + 7);
        push(b + 7, K_ERR, 32'd0, 32'd0, 32'd0, 72);
        push(b + 7, K_REQ, 32'd2, 32'd0, 32'd0, 73);
        width = 12'd640; height = 12'd480; bs_rest = 3'd5;
        frame_start = 1'b1;
        push_frame_hdr(b + 7, 12'd640, 12'd480, 3'd5);
        push(b + 8, K_ERR, 32'd1, 32'd0, 32'd0, 74);
        push(b + 8, K_REQ, 32'd0, 32'd0, 32'd0, 75);
        tick();
        frame_start = 1'b0;
        wait_until(b + 7 + 173);
        rst_seq();

        // 7x16: zero MCU columns, bands are counted without requests
        width = 12'd7; height = 12'd16; bs_rest = 3'd0;
        f = cyc;
        frame_start = 1'b1;
        push_frame_hdr(f, 12'd7, 12'd16, 3'd0);
        tick();
        frame_start = 1'b0;
        wait_until(f + 171);
        band_ready = 1'b1;
        for (int k = 172; k <= 176; k++) begin
            push(f + k, K_REQ, 32'd0, 32'd0, 32'd0, 80 + k);
        end
        push(f + 174, K_BUSY, 32'd1, 32'd0, 32'd0, 90);
        push(f + 175, K_BUSY, 32'd0, 32'd0, 32'd0, 91);
        push(f + 176, K_ERR,  32'd0, 32'd0, 32'd0, 92);
        tick();
        band_ready = 1'b0;
        tick();
        band_ready = 1'b1;
        tick();
        band_ready = 1'b0;

        wait_until(last_target + 1);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
